// File: rtl/bbox_stage.sv
// bbox_stage: first rasterizer stage. Builds a subsample-snapped, screen-clamped
// bounding box per triangle and culls off-screen and back-facing ones over R11..R13.
module bbox_stage #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R10S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R10U [COLORS],
    input  logic                     validTri_R10H,
    input  logic signed [SIGFIG-1:0] screen_RnnnnS [2],
    input  logic        [3:0]        subSample_RnnnnU,
    input  logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R13U [COLORS],
    output logic                     validTri_R13H,
    output logic signed [SIGFIG-1:0] box_R13S [2][2],
    output logic        [15:0]       cull_cnt_RnnnnU
);

    localparam int DW  = SIGFIG + 1;
    localparam int PW  = 2 * SIGFIG + 2;
    localparam int DDW = PW + 1;

    logic signed [SIGFIG-1:0] tri_R11_q [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R11_q [COLORS];
    logic                     valid_R11_q;
    logic signed [SIGFIG-1:0] box_R11_q [2][2];

    logic signed [SIGFIG-1:0] tri_R12_q [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R12_q [COLORS];
    logic                     valid_R12_q;
    logic                     offscreen_R12_q;
    logic signed [SIGFIG-1:0] box_R12_q [2][2];

    logic signed [SIGFIG-1:0] tri_R13_q [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13_q [COLORS];
    logic                     valid_R13_q;
    logic signed [SIGFIG-1:0] box_R13_q [2][2];
    logic        [15:0]       cull_cnt_q;

    logic signed [SIGFIG-1:0] box_R11_d [2][2];
    logic signed [SIGFIG-1:0] box_R12_d [2][2];
    logic                     offscreen_R12_d;
    logic                     valid_R13_d;

    // Per-axis signed min/max over the three vertices.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            box_R11_d[0][a] = tri_R10S[0][a];
            box_R11_d[1][a] = tri_R10S[0][a];
            for (int v = 1; v < VERTS; v++) begin
                if (tri_R10S[v][a] < box_R11_d[0][a]) begin
                    box_R11_d[0][a] = tri_R10S[v][a];
                end
                if (tri_R10S[v][a] > box_R11_d[1][a]) begin
                    box_R11_d[1][a] = tri_R10S[v][a];
                end
            end
        end
    end

    // Masking the low bits floors toward -inf in two's complement.
    logic [SIGFIG-1:0] snap_mask;
    always_comb begin
        case (subSample_RnnnnU)
            4'b0100: snap_mask = {SIGFIG{1'b1}} << (RADIX - 1);
            4'b0010: snap_mask = {SIGFIG{1'b1}} << (RADIX - 2);
            4'b0001: snap_mask = {SIGFIG{1'b1}} << (RADIX - 3);
            default: snap_mask = {SIGFIG{1'b1}} << RADIX;
        endcase
    end

    logic signed [SIGFIG-1:0] snap_ll [2];
    logic signed [SIGFIG-1:0] snap_ur [2];
    logic        [1:0]        off_axis;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_snap
            assign snap_ll[gi] = box_R11_q[0][gi] & snap_mask;
            assign snap_ur[gi] = box_R11_q[1][gi] & snap_mask;
            assign box_R12_d[0][gi] = snap_ll[gi][SIGFIG-1] ? '0 : snap_ll[gi];
            assign box_R12_d[1][gi] = (snap_ur[gi] > screen_RnnnnS[gi]) ? screen_RnnnnS[gi]
                                                                         : snap_ur[gi];
            // Off-screen decision uses the snapped but unclamped box.
            assign off_axis[gi] = snap_ur[gi][SIGFIG-1] | (snap_ll[gi] >= screen_RnnnnS[gi]);
        end
    endgenerate

    assign offscreen_R12_d = |off_axis;

    // Signed area term at full precision; negative means front-facing.
    logic signed [DW-1:0]  dx10, dy21, dx21, dy10;
    logic signed [PW-1:0]  prod_a, prod_b;
    logic signed [DDW-1:0] area_d;

    always_comb begin
        dx10   = DW'(tri_R12_q[1][0]) - DW'(tri_R12_q[0][0]);
        dy21   = DW'(tri_R12_q[2][1]) - DW'(tri_R12_q[1][1]);
        dx21   = DW'(tri_R12_q[2][0]) - DW'(tri_R12_q[1][0]);
        dy10   = DW'(tri_R12_q[1][1]) - DW'(tri_R12_q[0][1]);
        prod_a = PW'(dx10) * PW'(dy21);
        prod_b = PW'(dx21) * PW'(dy10);
        area_d = DDW'(prod_a) - DDW'(prod_b);
    end

    logic keep_R12;
    logic cull_R12;
    assign keep_R12    = ~offscreen_R12_q & area_d[DDW-1];
    assign valid_R13_d = valid_R12_q & keep_R12;
    assign cull_R12    = valid_R12_q & ~keep_R12;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    tri_R11_q[v][a] <= '0;
                    tri_R12_q[v][a] <= '0;
                    tri_R13_q[v][a] <= '0;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                color_R11_q[c] <= '0;
                color_R12_q[c] <= '0;
                color_R13_q[c] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                for (int a = 0; a < 2; a++) begin
                    box_R11_q[i][a] <= '0;
                    box_R12_q[i][a] <= '0;
                    box_R13_q[i][a] <= '0;
                end
            end
            valid_R11_q     <= 1'b0;
            valid_R12_q     <= 1'b0;
            valid_R13_q     <= 1'b0;
            offscreen_R12_q <= 1'b0;
            cull_cnt_q      <= '0;
        end else if (halt_RnnnnL) begin
            tri_R11_q       <= tri_R10S;
            color_R11_q     <= color_R10U;
            valid_R11_q     <= validTri_R10H;
            box_R11_q       <= box_R11_d;

            tri_R12_q       <= tri_R11_q;
            color_R12_q     <= color_R11_q;
            valid_R12_q     <= valid_R11_q;
            box_R12_q       <= box_R12_d;
            offscreen_R12_q <= offscreen_R12_d;

            tri_R13_q       <= tri_R12_q;
            color_R13_q     <= color_R12_q;
            valid_R13_q     <= valid_R13_d;
            box_R13_q       <= box_R12_q;

            if (cull_R12 && (cull_cnt_q != 16'hFFFF)) begin
                cull_cnt_q <= cull_cnt_q + 16'd1;
            end
        end
    end

    assign tri_R13S        = tri_R13_q;
    assign color_R13U      = color_R13_q;
    assign validTri_R13H   = valid_R13_q;
    assign box_R13S        = box_R13_q;
    assign cull_cnt_RnnnnU = cull_cnt_q;

endmodule

// File: tb/tb_bbox_stage.sv
// Self-checking bench for bbox_stage: a triangle-level reference model predicts
// every R13 output, and directed cases pin the documented numeric results.
module tb_bbox_stage;

    localparam int RADIX = 10;

    logic clk = 1'b0;
    logic rst;
    logic signed [23:0] tri_R10S [3][3];
    logic        [23:0] color_R10U [3];
    logic               validTri_R10H;
    logic signed [23:0] screen_RnnnnS [2];
    logic        [3:0]  subSample_RnnnnU;
    logic               halt_RnnnnL;
    logic signed [23:0] tri_R13S [3][3];
    logic        [23:0] color_R13U [3];
    logic               validTri_R13H;
    logic signed [23:0] box_R13S [2][2];
    logic        [15:0] cull_cnt_RnnnnU;

    int checks = 0;
    int fails  = 0;

    bbox_stage dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R10S         (tri_R10S),
        .color_R10U       (color_R10U),
        .validTri_R10H    (validTri_R10H),
        .screen_RnnnnS    (screen_RnnnnS),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .validTri_R13H    (validTri_R13H),
        .box_R13S         (box_R13S),
        .cull_cnt_RnnnnU  (cull_cnt_RnnnnU)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One triangle as it travels: raw data plus the box computed when it leaves R11.
    typedef struct packed {
        logic [8:0][23:0] t;
        logic [2:0][23:0] c;
        logic [3:0][23:0] box;
        logic             vld;
        logic             off;
    } ent_t;

    ent_t mq[$];   // [0]=R13, [1]=R12, [2]=R11
    int   exp_cull;

    function automatic longint sv(logic [23:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint floor_to(longint v, int m);
        longint s, q;
        s = longint'(1) << m;
        q = v / s;
        if ((v % s) != 0 && v < 0) q = q - 1;
        return q * s;
    endfunction

    function automatic int snap_bits(logic [3:0] s);
        case (s)
            4'b0100: return RADIX - 1;
            4'b0010: return RADIX - 2;
            4'b0001: return RADIX - 3;
            default: return RADIX;
        endcase
    endfunction

    function automatic longint area(ent_t e);
        longint x0, y0, x1, y1, x2, y2;
        x0 = sv(e.t[0]); y0 = sv(e.t[1]);
        x1 = sv(e.t[3]); y1 = sv(e.t[4]);
        x2 = sv(e.t[6]); y2 = sv(e.t[7]);
        return (x1 - x0) * (y2 - y1) - (x2 - x1) * (y1 - y0);
    endfunction

    function automatic bit kept(ent_t e);
        return !e.off && (area(e) < 0);
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '0;
        mq.delete();
        repeat (3) mq.push_back(z);
        exp_cull = 0;
    endtask

    task automatic model_edge();
        ent_t   n, e;
        int     m;
        longint lo, hi, scr, p;
        n = '0;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++) n.t[v*3+a] = tri_R10S[v][a];
        for (int c = 0; c < 3; c++) n.c[c] = color_R10U[c];
        n.vld = validTri_R10H;
        mq.push_back(n);
        e = mq[2];
        m = snap_bits(subSample_RnnnnU);
        e.off = 1'b0;
        for (int a = 0; a < 2; a++) begin
            lo = sv(e.t[a]);
            hi = lo;
            for (int v = 1; v < 3; v++) begin
                p = sv(e.t[v*3+a]);
                if (p < lo) lo = p;
                if (p > hi) hi = p;
            end
            lo  = floor_to(lo, m);
            hi  = floor_to(hi, m);
            scr = longint'(screen_RnnnnS[a]);
            if (hi < 0 || lo >= scr) e.off = 1'b1;
            if (lo < 0) lo = 0;
            if (hi > scr) hi = scr;
            e.box[a]   = 24'(lo);
            e.box[2+a] = 24'(hi);
        end
        mq[2] = e;
        void'(mq.pop_front());
        if (mq[0].vld && !kept(mq[0]) && exp_cull < 65535) exp_cull++;
    endtask

    function automatic logic [400:0] exp_snap();
        logic [400:0] s;
        ent_t e;
        e = mq[0];
        s = '0;
        s[400] = e.vld && kept(e);
        s[399:384] = 16'(exp_cull);
        for (int k = 0; k < 4; k++) s[383-24*k -: 24] = e.box[k];
        for (int i = 0; i < 9; i++) s[287-24*i -: 24] = e.t[i];
        for (int c = 0; c < 3; c++) s[71-24*c -: 24] = e.c[c];
        return s;
    endfunction

    function automatic logic [400:0] dut_snap();
        logic [400:0] s;
        s = '0;
        s[400] = validTri_R13H;
        s[399:384] = cull_cnt_RnnnnU;
        for (int k = 0; k < 4; k++) s[383-24*k -: 24] = box_R13S[k/2][k%2];
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++) s[287-24*(v*3+a) -: 24] = tri_R13S[v][a];
        for (int c = 0; c < 3; c++) s[71-24*c -: 24] = color_R13U[c];
        return s;
    endfunction

    task automatic tick();
        bit adv;
        @(posedge clk);
        adv = rst && halt_RnnnnL;
        if (adv) model_edge();
        @(negedge clk);
        if (adv && mq[0].vld)
            $display("xact R13: kept=%0d LL=(%0h,%0h) UR=(%0h,%0h) culls=%0d",
                     kept(mq[0]), mq[0].box[0], mq[0].box[1], mq[0].box[2], mq[0].box[3], exp_cull);
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input logic vld);
        tri_R10S[0][0] = 24'(x0); tri_R10S[0][1] = 24'(y0);
        tri_R10S[1][0] = 24'(x1); tri_R10S[1][1] = 24'(y1);
        tri_R10S[2][0] = 24'(x2); tri_R10S[2][1] = 24'(y2);
        for (int v = 0; v < 3; v++) tri_R10S[v][2] = 24'($urandom);
        for (int c = 0; c < 3; c++) color_R10U[c] = 24'($urandom);
        validTri_R10H = vld;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_snap() !== exp_snap()) begin
            fails++;
            $display("FAIL reset_async: got=%h exp=%h", dut_snap(), exp_snap());
        end
        checks++;
        if (validTri_R13H !== 1'b0 || cull_cnt_RnnnnU !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b cull=%0d, expected valid=0 cull=0",
                     validTri_R13H, cull_cnt_RnnnnU);
        end
        set_tri(32'h1000, 32'h1000, 32'h1000, 32'h3000, 32'h3000, 32'h1000, 1'b1);
        tick();
        checks++;
        if (dut_snap() !== exp_snap()) begin
            fails++;
            $display("FAIL reset_held: got=%h exp=%h", dut_snap(), exp_snap());
        end
        validTri_R10H = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int a, b;
        a = 'h2980; b = 'h5000;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_tri(a, a, a, b, b, a, 1'b1);
                1: set_tri(a, a, b, a, a, b, 1'b1);
                2: set_tri(0, 0, 'h400, 'h400, 'h800, 'h800, 1'b1);
                default: validTri_R10H = 1'b0;
            endcase
            tick();
            checks++;
            if (dut_snap() !== exp_snap()) begin
                fails++;
                $display("FAIL basic_cycle%0d: got=%h exp=%h", i, dut_snap(), exp_snap());
            end
            if (i == 2) begin
                checks++;
                if (validTri_R13H !== 1'b1 || box_R13S[0][0] !== 24'h2800 || box_R13S[0][1] !== 24'h2800 ||
                    box_R13S[1][0] !== 24'h5000 || box_R13S[1][1] !== 24'h5000 || cull_cnt_RnnnnU !== 16'd0) begin
                    fails++;
                    $display("FAIL basic_tri: got v=%b LL=(%h,%h) UR=(%h,%h) cull=%0d, expected v=1 LL=(2800,2800) UR=(5000,5000) cull=0",
                             validTri_R13H, box_R13S[0][0], box_R13S[0][1], box_R13S[1][0], box_R13S[1][1], cull_cnt_RnnnnU);
                end
            end
            if (i == 3) begin
                checks++;
                if (validTri_R13H !== 1'b0 || cull_cnt_RnnnnU !== 16'd1) begin
                    fails++;
                    $display("FAIL backface: got v=%b cull=%0d, expected v=0 cull=1", validTri_R13H, cull_cnt_RnnnnU);
                end
            end
            if (i == 4) begin
                checks++;
                if (validTri_R13H !== 1'b0 || cull_cnt_RnnnnU !== 16'd2) begin
                    fails++;
                    $display("FAIL collinear: got v=%b cull=%0d, expected v=0 cull=2", validTri_R13H, cull_cnt_RnnnnU);
                end
            end
        end
    endtask

    task automatic test_clamp();
        int   tv [4][6];
        logic ev [4];
        int   ell [4];
        int   eur [4];
        tv  = '{'{-'h1000, 'h1000, -'h1000, 'h8000, 'h90000, 'h1000},
                '{'h80000, 'h1000, 'h80000, 'h8000, 'h90000, 'h1000},
                '{0, 'h1000, 0, 'h8000, 'h4000, 'h1000},
                '{-1, 'h1000, -1, 'h8000, 'h4000, 'h1000}};
        ev  = '{1'b1, 1'b0, 1'b1, 1'b1};
        ell = '{0, 'h80000, 0, 0};
        eur = '{'h80000, 'h80000, 'h4000, 'h4000};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_tri(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5], 1'b1);
            else validTri_R10H = 1'b0;
            tick();
            if (i >= 2) begin
                checks++;
                if (validTri_R13H !== ev[i-2] || box_R13S[0][0] !== 24'(ell[i-2]) ||
                    box_R13S[1][0] !== 24'(eur[i-2])) begin
                    fails++;
                    $display("FAIL clamp_tri%0d: got v=%b LLx=%h URx=%h, expected v=%b LLx=%h URx=%h",
                             i - 2, validTri_R13H, box_R13S[0][0], box_R13S[1][0], ev[i-2], 24'(ell[i-2]), 24'(eur[i-2]));
                end
            end
            checks++;
            if (dut_snap() !== exp_snap()) begin
                fails++;
                $display("FAIL clamp_cycle%0d: got=%h exp=%h", i, dut_snap(), exp_snap());
            end
        end
        checks++;
        if (cull_cnt_RnnnnU !== 16'd3) begin
            fails++;
            $display("FAIL clamp_cull_count: got %0d, expected 3", cull_cnt_RnnnnU);
        end
    endtask

    task automatic test_msaa();
        logic [3:0] subs [5];
        int         ell  [5];
        subs = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0110};
        ell  = '{'h2800, 'h2A00, 'h2B00, 'h2B80, 'h2800};
        for (int k = 0; k < 5; k++) begin
            subSample_RnnnnU = subs[k];
            set_tri('h2BFF, 'h2BFF, 'h2BFF, 'h5000, 'h5000, 'h2BFF, 1'b1);
            tick();
            validTri_R10H = 1'b0;
            tick();
            tick();
            checks++;
            if (validTri_R13H !== 1'b1 || box_R13S[0][0] !== 24'(ell[k]) || box_R13S[0][1] !== 24'(ell[k])) begin
                fails++;
                $display("FAIL msaa_sub%b: got v=%b LL=(%h,%h), expected v=1 LL=(%h,%h)",
                         subs[k], validTri_R13H, box_R13S[0][0], box_R13S[0][1], 24'(ell[k]), 24'(ell[k]));
            end
            checks++;
            if (dut_snap() !== exp_snap()) begin
                fails++;
                $display("FAIL msaa_model%0d: got=%h exp=%h", k, dut_snap(), exp_snap());
            end
        end
        subSample_RnnnnU = 4'b0100;
    endtask

    task automatic test_stall();
        logic [400:0] frozen;
        int           seen [$];
        int           want [3];
        int           a;
        validTri_R10H = 1'b0;
        repeat (3) tick();
        for (int t = 0; t < 3; t++) want[t] = 'h4000 * (t + 1);
        for (int step = 0; step < 12; step++) begin
            if (step < 3) begin
                a = want[step];
                set_tri(a, a, a, a + 'h3000, a + 'h3000, a, 1'b1);
            end
            if (step == 2) begin
                halt_RnnnnL = 1'b0;
                frozen = dut_snap();
                repeat (5) begin
                    tick();
                    checks++;
                    if (dut_snap() !== frozen || dut_snap() !== exp_snap()) begin
                        fails++;
                        $display("FAIL stall_frozen: got=%h held=%h", dut_snap(), frozen);
                    end
                end
                halt_RnnnnL = 1'b1;
            end
            tick();
            if (step >= 2) validTri_R10H = 1'b0;
            if (validTri_R13H === 1'b1) seen.push_back(int'(box_R13S[0][0]));
            checks++;
            if (dut_snap() !== exp_snap()) begin
                fails++;
                $display("FAIL stall_cycle%0d: got=%h exp=%h", step, dut_snap(), exp_snap());
            end
        end
        checks++;
        if (seen.size() != 3) begin
            fails++;
            $display("FAIL stall_count: got %0d triangles out, expected 3", seen.size());
        end
        for (int t = 0; t < 3 && t < seen.size(); t++) begin
            checks++;
            if (seen[t] != want[t]) begin
                fails++;
                $display("FAIL stall_order%0d: got LLx=%h, expected %h", t, seen[t], want[t]);
            end
        end
    endtask

    task automatic test_random();
        int c [6];
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                screen_RnnnnS[0] = 24'('h40000 + $urandom_range(0, 'h40000));
                screen_RnnnnS[1] = 24'('h40000 + $urandom_range(0, 'h40000));
            end
            case ($urandom_range(0, 7))
                0: subSample_RnnnnU = 4'b1000;
                1: subSample_RnnnnU = 4'b0100;
                2: subSample_RnnnnU = 4'b0010;
                3: subSample_RnnnnU = 4'b0001;
                4: subSample_RnnnnU = 4'($urandom);
                default: ;
            endcase
            halt_RnnnnL = ($urandom_range(0, 4) != 0);
            if (halt_RnnnnL) begin
                for (int k = 0; k < 6; k++) begin
                    if ($urandom_range(0, 3) == 0) c[k] = int'($urandom);
                    else c[k] = int'($urandom_range(0, 'hB0000)) - 'h10000;
                end
                set_tri(c[0], c[1], c[2], c[3], c[4], c[5], 1'($urandom_range(0, 3) != 0));
            end
            tick();
            checks++;
            if (dut_snap() !== exp_snap()) begin
                fails++;
                $display("FAIL random_cycle%0d: got=%h exp=%h", i, dut_snap(), exp_snap());
            end
        end
        halt_RnnnnL = 1'b1;
        subSample_RnnnnU = 4'b0100;
        screen_RnnnnS[0] = 24'h80000;
        screen_RnnnnS[1] = 24'h80000;
    endtask

    task automatic test_async_reset();
        int a;
        validTri_R10H = 1'b0;
        repeat (3) tick();
        for (int t = 0; t < 3; t++) begin
            a = 'h2000 * (t + 1);
            set_tri(a, a, a, a + 'h1000, a + 'h1000, a, 1'b1);
            tick();
        end
        validTri_R10H = 1'b0;
        checks++;
        if (validTri_R13H !== 1'b1) begin
            fails++;
            $display("FAIL areset_inflight: got v=%b, expected v=1 before reset", validTri_R13H);
        end
        #2 rst = 1'b0;
        #1 model_reset();
        checks++;
        if (dut_snap() !== exp_snap() || validTri_R13H !== 1'b0 || cull_cnt_RnnnnU !== 16'd0) begin
            fails++;
            $display("FAIL areset_immediate: got=%h exp=%h", dut_snap(), exp_snap());
        end
        halt_RnnnnL = 1'b0;
        tick();
        checks++;
        if (dut_snap() !== exp_snap()) begin
            fails++;
            $display("FAIL areset_with_stall: got=%h exp=%h", dut_snap(), exp_snap());
        end
        halt_RnnnnL = 1'b1;
        rst = 1'b1;
        set_tri('h1000, 'h1000, 'h1000, 'h2000, 'h2000, 'h1000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            validTri_R10H = 1'b0;
            checks++;
            if (validTri_R13H !== (i == 2)) begin
                fails++;
                $display("FAIL areset_release%0d: got v=%b, expected v=%b", i, validTri_R13H, (i == 2));
            end
            checks++;
            if (dut_snap() !== exp_snap()) begin
                fails++;
                $display("FAIL areset_model%0d: got=%h exp=%h", i, dut_snap(), exp_snap());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        halt_RnnnnL = 1'b1;
        subSample_RnnnnU = 4'b0100;
        screen_RnnnnS[0] = 24'h80000;
        screen_RnnnnS[1] = 24'h80000;
        set_tri(0, 0, 0, 0, 0, 0, 1'b0);
        model_reset();
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_msaa();
        test_stall();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bbox_stage.md
# bbox_stage

First rasterizer pipeline stage. It consumes the triangle stream produced by the rasterizer driver (R10 signals) and computes each triangle's screen-space bounding box. The box is snapped to the active subsample grid and clamped to the screen. Off-screen and back-facing/degenerate triangles are culled. The stage registers its results through a three-deep stall-able pipeline (R11–R13) that feeds the sample iterator.

## Interface
- SIGFIG, 24, bits in color and position
- RADIX, 10, fraction bits in color and position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- tri_R10S  in  signed [SIGFIG-1:0] x [VERTS][AXIS]  input vertices
- color_R10U  in  [SIGFIG-1:0] x [COLORS]  input color
- validTri_R10H  in  1  input triangle valid
- screen_RnnnnS  in  signed [SIGFIG-1:0] x [2]  screen width [0], height [1], fixed point
- subSample_RnnnnU  in  4  one-hot MSAA select: 1000=1x, 0100=4x, 0010=16x, 0001=64x
- halt_RnnnnL  in  1  downstream ready; 0 = stall
- tri_R13S  out  signed [SIGFIG-1:0] x [VERTS][AXIS]  delayed vertices
- color_R13U  out  [SIGFIG-1:0] x [COLORS]  delayed color
- validTri_R13H  out  1  output triangle valid (post-cull)
- box_R13S  out  signed [SIGFIG-1:0] x [2][2]  [0]=LL, [1]=UR; [i][0]=x, [i][1]=y
- cull_cnt_RnnnnU  out  16  saturating count of culled valid triangles

## Operation
- Global stall: when halt_RnnnnL=0, every pipeline register (R11, R12, R13), every valid bit, and cull_cnt hold. Bubbles are not squeezed. Upstream already withholds new input while halt_RnnnnL=0, so R10 is sampled only when halt_RnnnnL=1.
- R10→R11: LL = per-axis minimum of the x/y values of the three vertices, UR = per-axis maximum. Comparisons are signed. Vertices, color and valid are registered alongside.
- R11→R12, snap: clear the low M bits of all four box coordinates (floor toward −inf, two's complement). M = RADIX for 1x, RADIX−1 for 4x, RADIX−2 for 16x, RADIX−3 for 64x. A non-one-hot subSample_RnnnnU is treated as 1x.
- R11→R12, clamp: LL coordinates below 0 become 0; UR coordinates above screen_RnnnnS[axis] become screen_RnnnnS[axis].
- R11→R12, off-screen test: flag the triangle if, on either axis, the snapped UR < 0 or the snapped LL >= screen_RnnnnS[axis]. The test uses pre-clamp values.
- R12→R13, orientation: D = (x1−x0)*(y2−y1) − (x2−x1)*(y1−y0). Differences are SIGFIG+1 bits signed, products 2*SIGFIG+2 bits signed, and there is no truncation before the sign test. The triangle is kept iff D < 0; D >= 0 (back-facing or zero-area) is culled.
- validTri_R13H = valid_R12 & ~offscreen_R12 & (D<0).
- When a triangle is culled, data outputs still update; only the valid bit is 0.
- cull_cnt_RnnnnU increments by 1 on each unstalled R12→R13 advance where valid_R12=1 and the triangle is culled. It saturates at 0xFFFF.

## Timing
- Latency: exactly 3 unstalled clock edges from R10 sample to R13 output. Throughput is 1 triangle/cycle.
- Each cycle with halt_RnnnnL=0 adds one cycle of latency. Outputs are stable throughout a stall.
- Reset (rst=0, asynchronous): all valid bits 0, box/tri/color registers 0, cull_cnt 0. Outputs reach these values immediately, without waiting for a clock edge.
- Reset asserted mid-stream discards every in-flight triangle. The first R10 sample after rst deasserts appears at R13 three unstalled edges later.
- If rst and a stall coincide, reset wins.
- Boundaries:
  - A box touching x=0 exactly is not off-screen.
  - LL x = screen width exactly is off-screen.
  - A coordinate of −1 LSB floors to −(1<<M) and then clamps to 0.

## Test plan
- Basic, 4x, 512x512 screen (0x80000): v0=(0x2980,0x2980), v1=(0x2980,0x5000), v2=(0x5000,0x2980), valid=1 → 3 cycles later validTri_R13H=1, LL=(0x2800,0x2800), UR=(0x5000,0x5000), cull_cnt=0.
- Backface: same triangle with v1 and v2 swapped (D>0) → validTri_R13H=0, cull_cnt=1. Collinear v0=(0,0), v1=(0x400,0x400), v2=(0x800,0x800) → culled, cull_cnt=2.
- Clamp and off-screen: front-facing triangle spanning x −0x1000…0x90000 → LL x=0, UR x=0x80000, valid=1. Triangle with all x ≥ 0x80000 → valid=0, counted as culled.
- MSAA sweep: LL x=0x2BFF under 1x/4x/16x/64x → 0x2800/0x2A00/0x2B00/0x2B80.
- Stall: issue 3 back-to-back triangles, hold halt_RnnnnL=0 for 5 cycles after the second → outputs frozen during the stall, order preserved, each triangle appears exactly once.
- Async reset: assert rst=0 between clock edges with 3 valid triangles in flight → validTri_R13H=0 and cull_cnt=0 before the next edge. No in-flight triangle emerges after release.
